// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_pkg;

    // Widest circuit the checker supports; the truth table is 2^MAX_N_IN bits.
    localparam int unsigned MAX_N_IN = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    // Ceiling log2, usable in constant expressions; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned w;
        result = 0;
        if (value > 1) begin
            w = value - 1;
            while (w > 0) begin
                w = w >> 1;
                result++;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a W-bit vector.
module tt_popcount
    import tt_pkg::*;
#(
    parameter int unsigned W = 8,
    localparam int unsigned CW = clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] count
);

    // Sum the set bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2^N_IN input rows through a circuit, samples its output once per row and
// compares the collected table against a latched expected truth table.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned HOLD_CYC   = 4,
    parameter int unsigned SETTLE_CYC = 2,
    localparam int unsigned TT_W      = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] expected_tt,
    output logic [N_IN-1:0] stim,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TT_W-1:0] observed_tt,
    output logic [N_IN:0]   err_count
);

    if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
        $error("tt_sweep_checker: N_IN must be in 1..%0d", MAX_N_IN);
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("tt_sweep_checker: HOLD_CYC must be >= 1");
    end
    if (SETTLE_CYC >= HOLD_CYC) begin : g_bad_settle
        $error("tt_sweep_checker: SETTLE_CYC must be < HOLD_CYC");
    end

    localparam int unsigned HW = clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] SettleIdx = HW'(SETTLE_CYC);
    // Row counter is one bit wider than stim so the last-row compare never wraps.
    localparam logic [N_IN:0] RowLast = (N_IN + 1)'(TT_W - 1);
    localparam logic [N_IN:0] RowOne = (N_IN + 1)'(1);

    state_e          state_q;
    state_e          state_d;
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] obs_q;
    logic            pass_q;
    logic [N_IN:0]   err_q;
    logic [N_IN:0]   row_q;
    logic [HW-1:0]   hold_q;
    logic [TT_W-1:0] diff;
    logic [N_IN:0]   err_cnt;
    logic            hold_last;
    logic            row_last;

    assign hold_last = (hold_q == HoldLast);
    assign row_last  = (row_q == RowLast);
    assign diff      = obs_q ^ exp_q;

    tt_popcount #(
        .W (TT_W)
    ) u_popcount (
        .vec   (diff),
        .count (err_cnt)
    );

    // Next-state logic: a start is only seen from idle, so busy/finish starts are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StRun;
            StRun:    if (hold_last && row_last) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, row/hold counters, sampled table and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            exp_q   <= '0;
            obs_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        exp_q  <= expected_tt;
                        obs_q  <= '0;
                        pass_q <= 1'b0;
                        err_q  <= '0;
                        row_q  <= '0;
                        hold_q <= '0;
                    end
                end
                StRun: begin
                    if (hold_q == SettleIdx) begin
                        obs_q[row_q[N_IN-1:0]] <= dut_out;
                    end
                    if (hold_last) begin
                        // On the final row the counter stays put so stim keeps the last row.
                        if (!row_last) begin
                            row_q  <= row_q + RowOne;
                            hold_q <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                StFinish: begin
                    pass_q <= (obs_q == exp_q);
                    err_q  <= err_cnt;
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StFinish);
    end

    assign stim        = row_q[N_IN-1:0];
    assign pass        = pass_q;
    assign observed_tt = obs_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: a default checker driving a configurable model circuit, plus a
// 1-input, 1-cycle-per-row checker driving an inverter.
module tb_tt_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expected_tt = 8'h00;
    logic [2:0] stim;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] observed_tt;
    logic [3:0] err_count;

    logic       start1 = 1'b0;
    logic [1:0] expected_tt1 = 2'b00;
    logic [0:0] stim1;
    logic       dut_out1;
    logic       busy1;
    logic       done1;
    logic       pass1;
    logic [1:0] observed_tt1;
    logic [1:0] err_count1;

    int checks = 0;
    int errors = 0;
    int n;

    // Circuit model: mode 0 = 0xC3 function, 1 = tied 0, 2 = inverted 0xC3.
    // depth = extra register stages after the checker's own stim register, so a
    // "k register stage" circuit uses depth k-1.
    int         mode = 0;
    int         depth = 0;
    logic [7:0] ref_tt = 8'hC3;
    logic       fv;
    logic       p1 = 1'b0;
    logic       p2 = 1'b0;
    logic       p3 = 1'b0;

    always #5 clk = ~clk;

    assign fv = ref_tt[stim];

    always @(posedge clk) begin
        p1 <= fv;
        p2 <= p1;
        p3 <= p2;
    end

    always_comb begin
        case (depth)
            1:       dut_out = p1;
            2:       dut_out = p2;
            3:       dut_out = p3;
            default: dut_out = fv;
        endcase
        if (mode == 1) dut_out = 1'b0;
        else if (mode == 2) dut_out = ~fv;
    end

    assign dut_out1 = ~stim1[0];

    tt_sweep_checker dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .expected_tt (expected_tt),
        .stim        (stim),
        .dut_out     (dut_out),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .observed_tt (observed_tt),
        .err_count   (err_count)
    );

    tt_sweep_checker #(
        .N_IN       (1),
        .HOLD_CYC   (1),
        .SETTLE_CYC (0)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start       (start1),
        .expected_tt (expected_tt1),
        .stim        (stim1),
        .dut_out     (dut_out1),
        .busy        (busy1),
        .done        (done1),
        .pass        (pass1),
        .observed_tt (observed_tt1),
        .err_count   (err_count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full default sweep; expected_tt is flipped mid-sweep to show the latched copy
    // is used. Optionally pulses start during the done cycle, which must be ignored.
    task automatic sweep(input logic [7:0] exp_tt, input bit start_at_done, input string tag);
        @(negedge clk);
        expected_tt = exp_tt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 5) expected_tt = ~exp_tt;
        end
        check({tag, "_latency"}, 32'(n), 32'd33);
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_stim_last"}, 32'(stim), 32'd7);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_obs", 32'(observed_tt), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst1_busy", 32'(busy1), 32'd0);
        check("rst1_obs", 32'(observed_tt1), 32'd0);
        rst = 1'b0;

        // Matching circuit, 1 register stage.
        mode = 0;
        depth = 0;
        sweep(8'hC3, 1'b0, "match");
        check("match_obs", 32'(observed_tt), 32'hC3);
        check("match_err", 32'(err_count), 32'd0);
        check("match_pass", 32'(pass), 32'd1);

        // Output tied low; also pulse start during the done cycle.
        mode = 1;
        sweep(8'hC3, 1'b1, "tied0");
        check("tied0_obs", 32'(observed_tt), 32'h00);
        check("tied0_err", 32'(err_count), 32'd4);
        check("tied0_pass", 32'(pass), 32'd0);

        // Inverted circuit.
        mode = 2;
        sweep(8'hC3, 1'b0, "inv");
        check("inv_obs", 32'(observed_tt), 32'h3C);
        check("inv_err", 32'(err_count), 32'd8);
        check("inv_pass", 32'(pass), 32'd0);

        // 3 register stages: still settles in time.
        mode = 0;
        depth = 2;
        sweep(8'hC3, 1'b0, "stg3");
        check("stg3_obs", 32'(observed_tt), 32'hC3);
        check("stg3_pass", 32'(pass), 32'd1);

        // 4 register stages: each row sees the previous row's response.
        depth = 3;
        sweep(8'hC3, 1'b0, "stg4");
        check("stg4_obs", 32'(observed_tt), 32'h87);
        check("stg4_err", 32'(err_count), 32'd2);
        check("stg4_pass", 32'(pass), 32'd0);

        // Start mid-sweep is ignored; reset mid-sweep clears everything at once.
        depth = 0;
        @(negedge clk);
        expected_tt = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (stim !== 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_row3", 32'(stim), 32'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_ignored", 32'(stim), 32'd4);
        check("restart_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        check("reach_row5", 32'(stim), 32'd5);
        rst = 1'b1;
        #1;
        check("midrst_stim", 32'(stim), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        check("midrst_obs", 32'(observed_tt), 32'd0);
        check("midrst_err", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep(8'hC3, 1'b0, "fresh");
        check("fresh_obs", 32'(observed_tt), 32'hC3);
        check("fresh_pass", 32'(pass), 32'd1);

        // One input, one cycle per row, combinational inverter.
        @(negedge clk);
        expected_tt1 = 2'b01;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (done1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("n1_latency", 32'(n), 32'd3);
        @(negedge clk);
        check("n1_busy_after", 32'(busy1), 32'd0);
        check("n1_obs", 32'(observed_tt1), 32'h1);
        check("n1_err", 32'(err_count1), 32'd0);
        check("n1_pass", 32'(pass1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
